seq_limb_subtractor: RTL

Streaming multi-limb subtractor: computes A − B for operands of arbitrary length presented one WIDTH-bit limb per transfer, least-significant limb first. Borrow propagates between limbs in an internal register. The block uses valid/ready handshakes on both sides with a two-stage registered pipeline: an input capture stage and a result stage. It is the subtract-direction counterpart of the team's registered carry-chained adder, and it feeds the datapath's wide-compare and decrement paths.

---
 rtl/seq_limb_subtractor.sv | 125 ++++++++++++
 1 files changed

// File: rtl/seq_limb_subtractor.sv
// Streaming multi-limb subtractor (A - B, LS limb first) with a registered
// input capture stage and a registered result stage, valid/ready on both sides.
module seq_limb_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow,
  output logic             out_last,
  output logic             out_neg,
  output logic [7:0]       out_index,
  output logic             out_err
);

  typedef enum logic {
    ST_IDLE,
    ST_OPEN
  } op_state_t;

  op_state_t        r_state;
  logic             r_borrow_st;
  logic [7:0]       r_idx;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s1_first;
  logic             r_s1_last;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_diff;
  logic             r_s2_borrow;
  logic             r_s2_last;
  logic             r_s2_neg;
  logic [7:0]       r_s2_index;
  logic             r_s2_err;

  logic             w_s2_free;
  logic             w_adv;
  logic             w_accept;
  logic             w_open;
  logic             w_fresh;
  logic             w_bin;
  logic [WIDTH:0]   w_wide;
  logic [7:0]       w_idx_next;
  logic             w_err;

  assign w_s2_free = !r_s2_valid || out_ready;
  assign w_adv     = r_s1_valid && w_s2_free;
  assign in_ready  = !r_s1_valid || w_s2_free;
  assign w_accept  = in_valid && in_ready;

  // A limb starts fresh (no borrow, index 0) on in_first or when nothing is open;
  // the latter is the protocol-error case.
  assign w_open     = (r_state == ST_OPEN);
  assign w_fresh    = r_s1_first || !w_open;
  assign w_bin      = w_fresh ? 1'b0 : r_borrow_st;
  assign w_wide     = {1'b0, r_s1_a} - {1'b0, r_s1_b} - {{WIDTH{1'b0}}, w_bin};
  assign w_idx_next = w_fresh ? 8'd0 : ((r_idx == 8'hFF) ? 8'hFF : r_idx + 8'd1);
  assign w_err      = !r_s1_first && !w_open;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_borrow_st <= 1'b0;
      r_idx       <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_first  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_diff   <= '0;
      r_s2_borrow <= 1'b0;
      r_s2_last   <= 1'b0;
      r_s2_neg    <= 1'b0;
      r_s2_index  <= '0;
      r_s2_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_a     <= in_a;
        r_s1_b     <= in_b;
        r_s1_first <= in_first;
        r_s1_last  <= in_last;
      end else if (w_adv) begin
        r_s1_valid <= 1'b0;
      end

      // Borrow/index state moves only when a limb enters the result stage.
      if (w_adv) begin
        r_s2_valid  <= 1'b1;
        r_s2_diff   <= w_wide[WIDTH-1:0];
        r_s2_borrow <= w_wide[WIDTH];
        r_s2_last   <= r_s1_last;
        r_s2_neg    <= r_s1_last && w_wide[WIDTH];
        r_s2_index  <= w_idx_next;
        r_s2_err    <= w_err;
        r_state     <= r_s1_last ? ST_IDLE : ST_OPEN;
        r_borrow_st <= r_s1_last ? 1'b0 : w_wide[WIDTH];
        r_idx       <= w_idx_next;
      end else if (out_ready) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_diff   = r_s2_diff;
  assign out_borrow = r_s2_borrow;
  assign out_last   = r_s2_last;
  assign out_neg    = r_s2_neg;
  assign out_index  = r_s2_index;
  assign out_err    = r_s2_err;

endmodule
